// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer_if
// Desc     : Command, ALU-pin and response bundle for alu_cmd_sequencer.
//            "slave" is the sequencer's view. "master" is the environment:
//            the command producer, the ALU and the response consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
    parameter int INPUT_WIDTH  = 5,
    parameter int OUTPUT_WIDTH = 6,
    parameter int A_OP_WIDTH   = 3,
    parameter int B_OP_WIDTH   = 2,
    parameter int TAG_WIDTH    = 4
);
    // Command channel
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_mode;
    logic [A_OP_WIDTH-1:0]   cmd_op;
    logic [INPUT_WIDTH-1:0]  cmd_a;
    logic [INPUT_WIDTH-1:0]  cmd_b;
    logic [TAG_WIDTH-1:0]    cmd_tag;

    // ALU pins
    logic                    alu_en;
    logic                    a_en;
    logic                    b_en;
    logic [A_OP_WIDTH-1:0]   a_op;
    logic [B_OP_WIDTH-1:0]   b_op;
    logic [INPUT_WIDTH-1:0]  alu_a;
    logic [INPUT_WIDTH-1:0]  alu_b;
    logic [OUTPUT_WIDTH-1:0] alu_c;

    // Response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [OUTPUT_WIDTH-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic                    rsp_err;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_en, a_en, b_en, a_op, b_op, alu_a, alu_b,
        input  alu_c,
        output rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_en, a_en, b_en, a_op, b_op, alu_a, alu_b,
        output alu_c,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Desc     : Front-end for the ALU. It buffers commands and issues one per
//            cycle onto the ALU pins. It then captures the registered ALU
//            result together with the command tag in a response FIFO.
//            Credit-based issue (response count + in-flight < DEPTH) means a
//            stalled consumer never causes a result to be lost.
// Options  : define ALU_SEQ_PERF_CNT_EN to add the saturating perf_issued and
//            perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int INPUT_WIDTH  = 5,
    parameter int OUTPUT_WIDTH = 6,
    parameter int A_OP_WIDTH   = 3,
    parameter int B_OP_WIDTH   = 2,
    parameter int DEPTH        = 4,
    parameter int TAG_WIDTH    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_cmd_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        perf_issued,
    output logic [15:0]        perf_stall
`endif
);
    localparam int         c_PTR_W    = $clog2(DEPTH);
    localparam int         c_USE_W    = c_PTR_W + 2;
    localparam logic [1:0] c_MODE_INV = 2'b00;
    localparam logic [1:0] c_MODE_A   = 2'b01;
    localparam logic [1:0] c_MODE_B11 = 2'b11;
    localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic [1:0]             mode;
        logic [A_OP_WIDTH-1:0]  op;
        logic [INPUT_WIDTH-1:0] a;
        logic [INPUT_WIDTH-1:0] b;
        logic [TAG_WIDTH-1:0]   tag;
    } cmd_t;

    typedef struct packed {
        logic [OUTPUT_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]    tag;
        logic                    err;
    } rsp_t;

    cmd_t                    r_cmd_mem [DEPTH];
    rsp_t                    r_rsp_mem [DEPTH];
    logic [c_PTR_W:0]        r_cmd_wr, r_cmd_rd, r_rsp_wr, r_rsp_rd;

    logic                    r_s1_valid, r_s1_err, r_s2_valid, r_s2_err;
    logic [TAG_WIDTH-1:0]    r_s1_tag, r_s2_tag;
    logic                    r_alu_en, r_a_en, r_b_en;
    logic [A_OP_WIDTH-1:0]   r_a_op;
    logic [B_OP_WIDTH-1:0]   r_b_op;
    logic [INPUT_WIDTH-1:0]  r_alu_a, r_alu_b;

    logic                    w_cmd_empty, w_cmd_full, w_cmd_push;
    logic                    w_rsp_empty, w_rsp_pop;
    logic [c_PTR_W:0]        w_rsp_count;
    logic [c_USE_W-1:0]      w_used;
    logic                    w_credit_ok, w_issue, w_issue_ok;
    cmd_t                    w_cmd_in, w_head;
    rsp_t                    w_rsp_in, w_rsp_head;
    logic [OUTPUT_WIDTH-1:0] w_rsp_data;

    // ---------------------------------------------------------------- command FIFO
    assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
    assign w_cmd_full  = (r_cmd_wr[c_PTR_W] != r_cmd_rd[c_PTR_W]) &&
                         (r_cmd_wr[c_PTR_W-1:0] == r_cmd_rd[c_PTR_W-1:0]);
    assign bus.cmd_ready = !w_cmd_full;
    assign w_cmd_push  = bus.cmd_valid && !w_cmd_full;
    assign w_cmd_in    = {bus.cmd_mode, bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
    assign w_head      = r_cmd_mem[r_cmd_rd[c_PTR_W-1:0]];

    // Command storage is not reset; the pointers alone determine validity.
    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wr[c_PTR_W-1:0]] <= w_cmd_in;
        end
    end

    // ---------------------------------------------------------------- credit / issue
    // Every issued slot will land in the response FIFO, so reserve room for
    // it at issue time: queued responses plus S1/S2 must stay below DEPTH.
    assign w_rsp_count = r_rsp_wr - r_rsp_rd;
    assign w_used      = c_USE_W'(w_rsp_count) + c_USE_W'(r_s1_valid) + c_USE_W'(r_s2_valid);
    assign w_credit_ok = (w_used < c_USE_W'(DEPTH));
    assign w_issue     = !w_cmd_empty && w_credit_ok;
    assign w_issue_ok  = w_issue && (w_head.mode != c_MODE_INV);

    // S1 drives the ALU pins; every pin returns to 0 unless a valid mode issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_tag   <= '0;
            r_alu_en   <= 1'b0;
            r_a_en     <= 1'b0;
            r_b_en     <= 1'b0;
            r_a_op     <= '0;
            r_b_op     <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_err   <= w_issue && (w_head.mode == c_MODE_INV);
            r_s1_tag   <= w_issue ? w_head.tag : '0;
            r_alu_en   <= w_issue_ok;
            r_a_en     <= w_issue_ok && w_head.mode[0];
            r_b_en     <= w_issue_ok && w_head.mode[1];
            r_a_op     <= (w_issue_ok && (w_head.mode == c_MODE_A)) ? w_head.op : '0;
            r_b_op     <= (w_issue_ok && w_head.mode[1]) ? w_head.op[B_OP_WIDTH-1:0] : '0;
            r_alu_a    <= w_issue_ok ? w_head.a : '0;
            r_alu_b    <= w_issue_ok ? w_head.b : '0;
        end
    end

    assign bus.alu_en = r_alu_en;
    assign bus.a_en   = r_a_en;
    assign bus.b_en   = r_b_en;
    assign bus.a_op   = r_a_op;
    assign bus.b_op   = r_b_op;
    assign bus.alu_a  = r_alu_a;
    assign bus.alu_b  = r_alu_b;

    // S2 tracks the slot while the ALU registers its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_tag   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= r_s1_err;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // ---------------------------------------------------------------- response FIFO
    assign w_rsp_data  = r_s2_err ? {OUTPUT_WIDTH{1'b0}} : bus.alu_c;
    assign w_rsp_in    = {w_rsp_data, r_s2_tag, r_s2_err};
    assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);
    assign w_rsp_pop   = !w_rsp_empty && bus.rsp_ready;
    assign w_rsp_head  = w_rsp_empty ? '0 : r_rsp_mem[r_rsp_rd[c_PTR_W-1:0]];

    assign bus.rsp_valid = !w_rsp_empty;
    assign bus.rsp_data  = w_rsp_head.data;
    assign bus.rsp_tag   = w_rsp_head.tag;
    assign bus.rsp_err   = w_rsp_head.err;

    // Response storage; credit guarantees a free entry whenever S2 is valid.
    always_ff @(posedge clk) begin
        if (r_s2_valid) begin
            r_rsp_mem[r_rsp_wr[c_PTR_W-1:0]] <= w_rsp_in;
        end
    end

    // All FIFO pointers; reset empties both FIFOs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_wr <= '0;
            r_cmd_rd <= '0;
            r_rsp_wr <= '0;
            r_rsp_rd <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + c_PTR_ONE;
            if (w_issue)    r_cmd_rd <= r_cmd_rd + c_PTR_ONE;
            if (r_s2_valid) r_rsp_wr <= r_rsp_wr + c_PTR_ONE;
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + c_PTR_ONE;
        end
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] r_perf_issued, r_perf_stall;
    logic        w_stall;

    assign w_stall = !w_cmd_empty && !w_credit_ok;

    // Saturating counters: cycles with alu_en high, and credit-blocked cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_alu_en && (r_perf_issued != 16'hFFFF)) r_perf_issued <= r_perf_issued + 16'd1;
            if (w_stall  && (r_perf_stall  != 16'hFFFF)) r_perf_stall  <= r_perf_stall  + 16'd1;
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif
endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Desc     : Directed bench for alu_cmd_sequencer with a registered ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_alu_en = 0;

    alu_cmd_sequencer_if bus ();

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] perf_issued, perf_stall;
`endif

    alu_cmd_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: set A {add,sub,and,or,xor}, B01 {~a,~b,a+1,b+1}, B11 {-a,-b,a-1,b+2}
    function automatic logic [5:0] alu_model(input logic ae, input logic be,
                                              input logic [2:0] aop, input logic [1:0] bop,
                                              input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sa, sb;
        sa = {a[4], a};
        sb = {b[4], b};
        if (ae && !be) begin
            case (aop)
                3'd0:    return sa + sb;
                3'd1:    return sa - sb;
                3'd2:    return sa & sb;
                3'd3:    return sa | sb;
                3'd4:    return sa ^ sb;
                default: return sa;
            endcase
        end else if (!ae && be) begin
            case (bop)
                2'd0:    return ~sa;
                2'd1:    return ~sb;
                2'd2:    return sa + 6'd1;
                default: return sb + 6'd1;
            endcase
        end else begin
            case (bop)
                2'd0:    return -sa;
                2'd1:    return -sb;
                2'd2:    return sa - 6'd1;
                default: return sb + 6'd2;
            endcase
        end
    endfunction

    // Registered ALU result: holds its value when alu_en is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.alu_c <= '0;
        else if (bus.alu_en) bus.alu_c <= alu_model(bus.a_en, bus.b_en, bus.a_op, bus.b_op, bus.alu_a, bus.alu_b);
    end

    // Count alu_en pulses.
    always @(posedge clk) begin
        if (bus.alu_en === 1'b1) n_alu_en <= n_alu_en + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] m, input logic [2:0] op, input logic [4:0] a,
                             input logic [4:0] b, input logic [3:0] t);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = t;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_alu_en"},    bus.alu_en,    0);
        chk({tag, "_ab_en"},     {bus.a_en, bus.b_en}, 0);
        chk({tag, "_ops"},       {bus.a_op, bus.b_op}, 0);
        chk({tag, "_alu_ab"},    {bus.alu_a, bus.alu_b}, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_flds"},  {bus.rsp_data, bus.rsp_tag, bus.rsp_err}, 0);
    endtask

    initial begin
        int idx, n_rx, exp_tag, base_en, n_stale;
`ifdef ALU_SEQ_PERF_CNT_EN
        logic [15:0] p0;
`endif
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = '0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Set-A add: 5 + 3 = 8, tag 2
        drive_cmd(2'b01, 3'd0, 5'd5, 5'd3, 4'd2);
        chk("seta_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("seta_c0_alu_en", bus.alu_en, 0);
        tick();
        chk("seta_c1_alu_en", bus.alu_en, 1);
        chk("seta_c1_ab_en",  {bus.a_en, bus.b_en}, 2'b10);
        chk("seta_c1_a_op",   bus.a_op, 0);
        chk("seta_c1_ab",     {bus.alu_a, bus.alu_b}, {5'd5, 5'd3});
        tick();
        chk("seta_c2_rsp_valid", bus.rsp_valid, 0);
        chk("seta_c2_alu_en",    bus.alu_en, 0);
        tick();
        chk("seta_c3_rsp_valid", bus.rsp_valid, 1);
        chk("seta_c3_rsp", {bus.rsp_data, bus.rsp_tag, bus.rsp_err}, {6'd8, 4'd2, 1'b0});
        tick();
        chk("seta_c4_rsp_valid", bus.rsp_valid, 0);

        // B11: a-1 with A=-16, then b+2 with B=15
        drive_cmd(2'b11, 3'd2, 5'h10, 5'd0, 4'd3);
        tick();
        drive_cmd(2'b11, 3'd3, 5'd0, 5'd15, 4'd4);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b11_c1_en", {bus.alu_en, bus.a_en, bus.b_en}, 3'b111);
        chk("b11_c1_b_op", bus.b_op, 2);
        chk("b11_c1_a_op", bus.a_op, 0);
        chk("b11_c1_alu_a", bus.alu_a, 5'h10);
        tick();
        chk("b11_c2_b_op", bus.b_op, 3);
        chk("b11_c2_alu_b", bus.alu_b, 5'd15);
        tick();
        chk("b11_rsp0", {bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err}, {1'b1, 6'h2F, 4'd3, 1'b0});
        tick();
        chk("b11_rsp1", {bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err}, {1'b1, 6'h11, 4'd4, 1'b0});
        tick();
        chk("b11_drained", bus.rsp_valid, 0);

        // Invalid mode: occupies a slot, pins stay 0, error response with data 0
        drive_cmd(2'b00, 3'd5, 5'd3, 5'd4, 4'd7);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("inv_c1_alu_en", bus.alu_en, 0);
        chk("inv_c1_pins", {bus.a_en, bus.b_en, bus.a_op, bus.b_op, bus.alu_a, bus.alu_b}, 0);
        tick();
        chk("inv_c2_rsp_valid", bus.rsp_valid, 0);
        tick();
        chk("inv_c3_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err}, {1'b1, 6'd0, 4'd7, 1'b1});
        tick();
        chk("inv_drained", bus.rsp_valid, 0);

        // Reset mid-stream with three commands in flight
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(2'b01, 3'd0, 5'd1, 5'd1, 4'(i + 1));
            tick();
        end
        bus.cmd_valid = 1'b0;
        tick();
        chk("rst_pre_rsp_valid", bus.rsp_valid, 1);
        chk("rst_pre_alu_en",    bus.alu_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk_all_zero("rst_release");
        bus.rsp_ready = 1'b1;
        n_stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.alu_en !== 1'b0) n_stale++;
        end
        chk("rst_no_stale", n_stale, 0);
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("perf_reset", {perf_issued, perf_stall}, 0);
`endif

        // Backpressure: 10 offered commands, consumer stalled
        bus.rsp_ready = 1'b0;
        base_en = n_alu_en;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            logic acc;
            if (idx < 10) drive_cmd(2'b01, 3'd0, 5'(idx), 5'd1, 4'(idx));
            else          bus.cmd_valid = 1'b0;
            acc = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (acc) idx++;
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted", idx, 8);
        chk("bp_cmd_ready", bus.cmd_ready, 0);
        chk("bp_alu_en_pulses", n_alu_en - base_en, 4);
        chk("bp_head", {bus.rsp_valid, bus.rsp_tag}, {1'b1, 4'd0});
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("perf_issued", perf_issued, 4);
        chk("perf_stall", perf_stall, 11);
        p0 = perf_stall;
        tick();
        chk("perf_stall_step", perf_stall, p0 + 16'd1);
`endif

        // Release: drain tags 0..7 in order, issue resumes one cycle after first pop
        bus.rsp_ready = 1'b1;
        n_rx = 0;
        exp_tag = 0;
        for (int c = 0; c < 40 && n_rx < 8; c++) begin
            if (c == 1) chk("bp_resume_early", bus.alu_en, 0);
            if (c == 2) chk("bp_resume_issue", bus.alu_en, 1);
            if (bus.rsp_valid === 1'b1) begin
                chk("bp_rsp_tag",  bus.rsp_tag,  4'(exp_tag));
                chk("bp_rsp_data", bus.rsp_data, 6'(exp_tag + 1));
                exp_tag++;
                n_rx++;
            end
            tick();
        end
        chk("bp_rx_count", n_rx, 8);
        repeat (4) tick();
        chk("bp_final_rsp_valid", bus.rsp_valid, 0);
        chk("bp_final_cmd_ready", bus.cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end placed directly upstream of the 6-bit ALU. It accepts operation commands over a valid/ready interface and buffers them in a command FIFO. It issues at most one command per cycle onto the ALU control and data pins, then collects the registered ALU result together with the command tag into a response FIFO. Credit-based issue guarantees that no result is ever dropped while the response consumer is stalled.

## Interface
Parameters:
- INPUT_WIDTH, default 5: operand width, matches ALU.
- OUTPUT_WIDTH, default 6: result width, matches ALU.
- A_OP_WIDTH, default 3: set-A opcode width.
- B_OP_WIDTH, default 2: set-B opcode width.
- DEPTH, default 4: entries in each of the command and response FIFOs; must be a power of 2 and at least 2.
- TAG_WIDTH, default 4: command tag width.

Ports:
- clk, input, 1: clock. rst_n, input, 1: reset, asynchronous, active-low.
- cmd_valid, input, 1 / cmd_ready, output, 1: command handshake.
- cmd_mode, input, 2: 01 = set A; 10 = set B01; 11 = set B11; 00 = invalid.
- cmd_op, input, A_OP_WIDTH: opcode; bits [B_OP_WIDTH-1:0] are used for B modes.
- cmd_a, cmd_b, input, INPUT_WIDTH each: signed operands. cmd_tag, input, TAG_WIDTH.
- alu_en, a_en, b_en, output, 1 each: ALU control pins.
- a_op, output, A_OP_WIDTH / b_op, output, B_OP_WIDTH / alu_a, alu_b, output, INPUT_WIDTH: ALU operand and opcode pins.
- alu_c, input, OUTPUT_WIDTH: ALU registered result C.
- rsp_valid, output, 1 / rsp_ready, input, 1: response handshake.
- rsp_data, output, OUTPUT_WIDTH; rsp_tag, output, TAG_WIDTH; rsp_err, output, 1.

## Operation
- **Command FIFO**
  - cmd_ready = !cmd_full. cmd_ready never depends on cmd_valid or on issue in the same cycle.
  - A push while full is impossible by construction.
  - Simultaneous push and pop is legal in every fill state.
- **Issue stage (S1 register)**
  - Issue condition: the command FIFO is non-empty AND (rsp_count + inflight) < DEPTH.
  - inflight is the number of valid entries in stages S1 and S2, range 0..2.
  - When an entry issues, the S1 register loads the ALU pins:
    - mode 01: a_en=1, b_en=0, a_op=cmd_op.
    - mode 10: a_en=0, b_en=1, b_op=cmd_op[B_OP_WIDTH-1:0].
    - mode 11: a_en=1, b_en=1, b_op=cmd_op[B_OP_WIDTH-1:0].
    - In every valid mode: alu_en=1, alu_a=cmd_a, alu_b=cmd_b.
  - Mode 00 still occupies a slot, which preserves response ordering. For mode 00, all ALU pins are driven 0, including alu_en=0.
  - In a cycle with no issue, every ALU pin is 0. Pins are never held from the previous command.
- **Capture (S2)**
  - The tag and the err flag (1 for mode 00, else 0) move from S1 to S2 one cycle later.
  - When S2 is valid, the response FIFO pushes {alu_c, tag, err}. For an err entry, data is forced to 0.
- **Response FIFO**
  - rsp_valid = !rsp_empty.
  - The head drives rsp_data, rsp_tag and rsp_err; pop on rsp_valid && rsp_ready.
  - Because of the credit rule, the FIFO can never overflow.
- **Reset behaviour**
  - Asynchronous reset clears both FIFOs, the S1/S2 valid bits, the pointers and the counters.
  - In-flight commands are discarded.

## Timing
- Reset values of all outputs:
  - cmd_ready=1.
  - alu_en=a_en=b_en=0; a_op, b_op, alu_a, alu_b = 0.
  - rsp_valid=0; rsp_data, rsp_tag, rsp_err = 0.
- Cycle-level latency, with an empty pipeline:
  - Cycle 0: command accepted.
  - Cycle 1: ALU pins are driven.
  - Cycle 2: alu_c is valid.
  - Cycle 3: rsp_valid=1.
- Sustained throughput is 1 command per cycle while rsp_ready=1.
- With rsp_ready=0, the block stops issuing after DEPTH outstanding responses. The command FIFO then fills, and cmd_ready drops after 2*DEPTH total accepted commands.
- A release of rsp_ready restores issue one cycle after the first pop.
- Responses return in command order.
- rst_n asserted mid-operation: outputs reach their reset values immediately, without waiting for a clock edge.

## Configuration
- ALU_SEQ_PERF_CNT_EN defined:
  - Adds output perf_issued[15:0], which counts valid-mode issues (alu_en=1 cycles) and saturates at 16'hFFFF.
  - Adds output perf_stall[15:0], which counts cycles where the command FIFO is non-empty but credit blocks issue; it also saturates.
  - Both counters reset to 0.
- ALU_SEQ_PERF_CNT_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- **Set-A add:** mode=01, op=0, A=5, B=3, tag=2, rsp_ready=1.
  - alu_en=1 in cycle 1.
  - Cycle 3: rsp_data=8, rsp_tag=2, rsp_err=0.
- **B11 ops:**
  - op=2, A=-16 -> rsp_data=6'h2F (-17).
  - op=3, B=15 -> rsp_data=6'h11.
  - Responses arrive in order.
- **Backpressure:** rsp_ready=0, 10 back-to-back commands with tags 0..9.
  - Exactly 8 are accepted, then cmd_ready=0.
  - Exactly 4 alu_en pulses occur.
  - After rsp_ready=1, tags 0..7 are returned in order with no loss.
- **Invalid mode:** mode=00, tag=7.
  - alu_en stays 0.
  - Response: rsp_err=1, rsp_data=0, rsp_tag=7, at cycle 3.
- **Reset mid-stream:** 3 commands in flight, then rst_n=0 for 2 cycles.
  - All outputs are 0, and cmd_ready=1 after release.
  - No stale response appears.
- **Performance counters (ALU_SEQ_PERF_CNT_EN):** backpressure scenario.
  - perf_issued=4 while stalled.
  - perf_stall increments once per blocked cycle.
